// File: rtl/regfile_scoreboard.sv
// Integer register file with NRP combinational read ports, two write ports and a pending-write scoreboard.
// Reads: zero latency (optional same-cycle bypass). Writes/busy/pend_cnt/pulses update on the clock edge.
// No backpressure: the hazard unit stalls on rd_busy; every write and issue presented is accepted.
module regfile_scoreboard #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRP    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NRP*AW-1:0]     rd_addr,
    output logic [NRP*XLEN-1:0]   rd_data,
    output logic [NRP-1:0]        rd_busy,
    input  logic                  wb0_en,
    input  logic [AW-1:0]         wb0_addr,
    input  logic [XLEN-1:0]       wb0_data,
    input  logic                  wb1_en,
    input  logic [AW-1:0]         wb1_addr,
    input  logic [XLEN-1:0]       wb1_data,
    input  logic                  issue_en,
    input  logic [AW-1:0]         issue_addr,
    input  logic                  flush,
    output logic [AW:0]           pend_cnt,
    output logic                  issue_err,
    output logic                  wr_conflict
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] busy_q, busy_d;
    logic [AW:0]      pend_cnt_q, pend_cnt_d;
    logic             issue_err_q, issue_err_d;
    logic             wr_conflict_q, wr_conflict_d;

    logic wb0_live, wb1_live, issue_live;

    assign wb0_live   = wb0_en && (wb0_addr != '0);
    assign wb1_live   = wb1_en && (wb1_addr != '0);
    assign issue_live = issue_en && (issue_addr != '0);

    // Read ports: bypass prefers WB0 since it carries the younger instruction.
    always_comb begin
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rdat;
        logic            rbusy;
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NRP; i++) begin
            ra    = rd_addr[i*AW +: AW];
            rdat  = regs_q[ra];
            rbusy = busy_q[ra];
            if (BYPASS != 0) begin
                if (wb0_live && (wb0_addr == ra)) begin
                    rdat = wb0_data;
                end else if (wb1_live && (wb1_addr == ra)) begin
                    rdat = wb1_data;
                end
                if (wb1_live && (wb1_addr == ra)) begin
                    rbusy = 1'b0;
                end
            end
            if (ra == '0) begin
                rdat  = '0;
                rbusy = 1'b0;
            end
            rd_data[i*XLEN +: XLEN] = rdat;
            rd_busy[i]              = rbusy;
        end
    end

    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            regs_d[r] = regs_q[r];
            if (r != 0) begin
                if (wb1_en && (wb1_addr == AW'(r))) regs_d[r] = wb1_data;
                if (wb0_en && (wb0_addr == AW'(r))) regs_d[r] = wb0_data;
            end
        end
        wr_conflict_d = wb0_live && wb1_en && (wb0_addr == wb1_addr);
    end

    // Issue is applied after retire so a same-cycle re-issue keeps the register busy.
    always_comb begin
        busy_d      = busy_q;
        issue_err_d = 1'b0;
        if (flush) begin
            busy_d = '0;
        end else begin
            if (wb1_live) busy_d[wb1_addr] = 1'b0;
            if (issue_live) begin
                busy_d[issue_addr] = 1'b1;
                issue_err_d = busy_q[issue_addr] && !(wb1_live && (wb1_addr == issue_addr));
            end
        end
        pend_cnt_d = '0;
        for (int r = 1; r < NREGS; r++) begin
            pend_cnt_d = pend_cnt_d + (AW+1)'(busy_d[r]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
            busy_q        <= '0;
            pend_cnt_q    <= '0;
            issue_err_q   <= 1'b0;
            wr_conflict_q <= 1'b0;
        end else begin
            regs_q        <= regs_d;
            busy_q        <= busy_d;
            pend_cnt_q    <= pend_cnt_d;
            issue_err_q   <= issue_err_d;
            wr_conflict_q <= wr_conflict_d;
        end
    end

    assign pend_cnt    = pend_cnt_q;
    assign issue_err   = issue_err_q;
    assign wr_conflict = wr_conflict_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Table-driven bench for regfile_scoreboard (BYPASS=1, NRP=2): each row drives one cycle
// and lists the outputs expected during that cycle; a hand sequence covers async reset.
module tb_regfile_scoreboard;

    logic        clk;
    logic        reset;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        wb0_en, wb1_en, issue_en, flush;
    logic [4:0]  wb0_addr, wb1_addr, issue_addr;
    logic [31:0] wb0_data, wb1_data;
    logic [5:0]  pend_cnt;
    logic        issue_err, wr_conflict;

    regfile_scoreboard #(.XLEN(32), .NREGS(32), .NRP(2), .BYPASS(1)) dut (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wb0_en(wb0_en), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
        .wb1_en(wb1_en), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
        .issue_en(issue_en), .issue_addr(issue_addr), .flush(flush),
        .pend_cnt(pend_cnt), .issue_err(issue_err), .wr_conflict(wr_conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        w0e; logic [4:0] w0a; logic [31:0] w0d;
        logic        w1e; logic [4:0] w1a; logic [31:0] w1d;
        logic        ie;  logic [4:0] ia;  logic        fl;
        logic [4:0]  ra0; logic [4:0] ra1;
        logic [31:0] d0;  logic [31:0] d1; logic [1:0]  b;
        logic [5:0]  pc;  logic        ierr; logic      wc;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d actual=0x%08h expected=0x%08h", name, row, act, exp);
        end
    endtask

    task automatic add(input logic w0e, input logic [4:0] w0a, input logic [31:0] w0d,
                       input logic w1e, input logic [4:0] w1a, input logic [31:0] w1d,
                       input logic ie, input logic [4:0] ia, input logic fl,
                       input logic [4:0] ra0, input logic [4:0] ra1,
                       input logic [31:0] d0, input logic [31:0] d1, input logic [1:0] b,
                       input logic [5:0] pc, input logic ierr, input logic wc);
        vec_t v;
        v.w0e = w0e; v.w0a = w0a; v.w0d = w0d;
        v.w1e = w1e; v.w1a = w1a; v.w1d = w1d;
        v.ie = ie; v.ia = ia; v.fl = fl; v.ra0 = ra0; v.ra1 = ra1;
        v.d0 = d0; v.d1 = d1; v.b = b; v.pc = pc; v.ierr = ierr; v.wc = wc;
        vecs.push_back(v);
    endtask

    task automatic idle_inputs();
        wb0_en = 0; wb0_addr = 0; wb0_data = 0;
        wb1_en = 0; wb1_addr = 0; wb1_data = 0;
        issue_en = 0; issue_addr = 0; flush = 0;
    endtask

    initial begin
        vec_t v, e;
        reset = 1'b0;
        rd_addr = '0;
        idle_inputs();

        //  w0e w0a w0d           w1e w1a w1d     ie ia fl  ra0 ra1  d0            d1            b      pc ierr wc
        add(0, 0, 0,            0, 0, 0,        0, 0, 0,  0,  1,  0,            0,            2'b00, 0, 0, 0); // reset state
        add(1, 3, 32'hDEADBEEF, 0, 0, 0,        0, 0, 0,  3,  3,  32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 0, 0, 0); // bypass
        add(0, 0, 0,            0, 0, 0,        0, 0, 0,  3,  0,  32'hDEADBEEF, 0,            2'b00, 0, 0, 0);
        add(1, 0, 32'h1234,     0, 0, 0,        1, 0, 0,  0,  0,  0,            0,            2'b00, 0, 0, 0); // x0
        add(0, 0, 0,            0, 0, 0,        0, 0, 0,  0,  3,  0,            32'hDEADBEEF, 2'b00, 0, 0, 0);
        add(0, 0, 0,            0, 0, 0,        1, 7, 0,  7,  3,  0,            32'hDEADBEEF, 2'b00, 0, 0, 0); // issue x7
        add(0, 0, 0,            0, 0, 0,        0, 0, 0,  7,  7,  0,            0,            2'b11, 1, 0, 0);
        add(0, 0, 0,            1, 7, 32'h55,   0, 0, 0,  7,  3,  32'h55,       32'hDEADBEEF, 2'b00, 1, 0, 0); // retire
        add(0, 0, 0,            0, 0, 0,        0, 0, 0,  7,  3,  32'h55,       32'hDEADBEEF, 2'b00, 0, 0, 0);
        add(1, 9, 32'hA,        1, 9, 32'hB,    0, 0, 0,  9,  9,  32'hA,        32'hA,        2'b00, 0, 0, 0); // conflict
        add(0, 0, 0,            0, 0, 0,        0, 0, 0,  9,  0,  32'hA,        0,            2'b00, 0, 0, 1);
        add(0, 0, 0,            0, 0, 0,        0, 0, 0,  9,  0,  32'hA,        0,            2'b00, 0, 0, 0);
        add(0, 0, 0,            0, 0, 0,        1, 4, 0,  4,  6,  0,            0,            2'b00, 0, 0, 0); // issue x4
        add(0, 0, 0,            0, 0, 0,        1, 6, 0,  4,  6,  0,            0,            2'b01, 1, 0, 0); // issue x6
        add(0, 0, 0,            0, 0, 0,        1, 4, 0,  4,  6,  0,            0,            2'b11, 2, 0, 0); // re-issue x4
        add(0, 0, 0,            0, 0, 0,        0, 0, 0,  4,  6,  0,            0,            2'b11, 2, 1, 0);
        add(0, 0, 0,            0, 0, 0,        1, 8, 1,  8,  4,  0,            0,            2'b10, 2, 0, 0); // flush+issue
        add(0, 0, 0,            0, 0, 0,        0, 0, 0,  8,  4,  0,            0,            2'b00, 0, 0, 0);
        add(0, 0, 0,            0, 0, 0,        1, 10, 0, 10, 9,  0,            32'hA,        2'b00, 0, 0, 0);
        add(0, 0, 0,            0, 0, 0,        0, 0, 0,  10, 9,  0,            32'hA,        2'b01, 1, 0, 0);
        add(0, 0, 0,            1, 10, 32'h77,  1, 10, 0, 10, 9,  32'h77,       32'hA,        2'b00, 1, 0, 0); // issue+retire
        add(0, 0, 0,            0, 0, 0,        0, 0, 0,  10, 9,  32'h77,       32'hA,        2'b01, 1, 0, 0);
        add(0, 0, 0,            1, 10, 32'h1,   0, 0, 0,  10, 9,  32'h1,        32'hA,        2'b00, 1, 0, 0);
        add(0, 0, 0,            0, 0, 0,        0, 0, 0,  10, 9,  32'h1,        32'hA,        2'b00, 0, 0, 0);
        add(1, 0, 32'h5,        1, 0, 32'h6,    0, 0, 0,  0,  9,  0,            32'hA,        2'b00, 0, 0, 0); // x0 both
        add(0, 0, 0,            0, 0, 0,        0, 0, 0,  0,  9,  0,            32'hA,        2'b00, 0, 0, 0);

        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            v = vecs[i];
            wb0_en = v.w0e; wb0_addr = v.w0a; wb0_data = v.w0d;
            wb1_en = v.w1e; wb1_addr = v.w1a; wb1_data = v.w1d;
            issue_en = v.ie; issue_addr = v.ia; flush = v.fl;
            rd_addr = {v.ra1, v.ra0};
            exp_q.push_back(v);
            #2;
            e = exp_q.pop_front();
            chk("rd_data0",    i, rd_data[31:0],  e.d0);
            chk("rd_data1",    i, rd_data[63:32], e.d1);
            chk("rd_busy",     i, {30'd0, rd_busy}, {30'd0, e.b});
            chk("pend_cnt",    i, {26'd0, pend_cnt}, {26'd0, e.pc});
            chk("issue_err",   i, {31'd0, issue_err}, {31'd0, e.ierr});
            chk("wr_conflict", i, {31'd0, wr_conflict}, {31'd0, e.wc});
        end

        // Async reset mid-run with x5 pending and x3 holding data.
        @(negedge clk);
        idle_inputs();
        wb0_en = 1; wb0_addr = 3; wb0_data = 32'hCAFE0003;
        issue_en = 1; issue_addr = 5;
        @(negedge clk);
        idle_inputs();
        rd_addr = {5'd3, 5'd5};
        #2;
        chk("pre_rst_busy", 100, {30'd0, rd_busy}, 32'h1);
        chk("pre_rst_cnt",  100, {26'd0, pend_cnt}, 32'h1);
        chk("pre_rst_x3",   100, rd_data[63:32], 32'hCAFE0003);
        #1 reset = 1'b0;
        #1;
        chk("rst_data0", 101, rd_data[31:0], 32'h0);
        chk("rst_data1", 101, rd_data[63:32], 32'h0);
        chk("rst_busy",  101, {30'd0, rd_busy}, 32'h0);
        chk("rst_cnt",   101, {26'd0, pend_cnt}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #2;
        chk("post_rst_x3",   102, rd_data[63:32], 32'h0);
        chk("post_rst_busy", 102, {30'd0, rd_busy}, 32'h0);
        chk("post_rst_cnt",  102, {26'd0, pend_cnt}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
